syn_fifo: RTL and testbench

//   Single-clock parametrised FIFO; successor to the dual-clock FIFO for same-domain buffering.

---
 rtl/syn_fifo_pkg.sv | 30 +++
 rtl/syn_fifo_mem.sv | 47 ++++
 rtl/syn_fifo.sv | 126 ++++++++++++
 tb/tb_syn_fifo.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/syn_fifo_pkg.sv
// Shared helpers for the single-clock FIFO: Gray-code conversion, which is common with
// the dual-clock FIFO, a level legality check, and the per-cycle access decision struct.
package syn_fifo_pkg;

    typedef struct packed {
        logic wr_acc;   // write stored this edge
        logic rd_acc;   // head word popped this edge
        logic ovf_evt;  // write attempted while full
        logic unf_evt;  // read attempted while empty
    } access_t;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 1; i < 32; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    // almost_full level must lie in 1..DEPTH, almost_empty level in 0..DEPTH-1.
    function automatic bit levels_ok(input int aw, input int af, input int ae);
        return (af >= 1) && (af <= (1 << aw)) && (ae >= 0) && (ae <= (1 << aw) - 1);
    endfunction

endpackage

// File: rtl/syn_fifo_mem.sv
// DEPTH x DATA_WIDTH register array with one write port and one read port.
// REG_RD=1 gives a registered read that is cleared by reset; REG_RD=0 reads combinationally.
module syn_fifo_mem #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int REG_RD     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    // Contents survive reset; only the pointers in the parent decide what is valid.
    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    generate
        if (REG_RD != 0) begin : g_reg_rd
            logic [DATA_WIDTH-1:0] r_rd_data;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd_data <= '0;
                end else if (i_rd_en) begin
                    r_rd_data <= r_mem[i_rd_addr];
                end
            end

            assign o_rd_data = r_rd_data;
        end else begin : g_comb_rd
            logic w_unused;
            assign w_unused  = rst | i_rd_en;
            assign o_rd_data = r_mem[i_rd_addr];
        end
    endgenerate

endmodule

// File: rtl/syn_fifo.sv
// Single-clock FIFO with fill count, almost-full/empty thresholds, optional FWFT output
// and sticky overflow/underflow flags. Holds pointers, count, flag decode and error state.
module syn_fifo
    import syn_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_wr,
    input  logic [DATA_WIDTH-1:0] Din,
    input  logic                  en_rd,
    output logic [DATA_WIDTH-1:0] Dout,
    output logic                  dout_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int                DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_C     = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_C     = AE_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    generate
        if (!levels_ok(ADDR_WIDTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
            $error("syn_fifo: AF_LEVEL must be 1..DEPTH and AE_LEVEL 0..DEPTH-1");
        end
    endgenerate

    logic [ADDR_WIDTH:0] r_wr_ptr;
    logic [ADDR_WIDTH:0] r_rd_ptr;
    logic [ADDR_WIDTH:0] r_count;
    logic                r_overflow;
    logic                r_underflow;
    access_t             w_acc;

    // Every status flag is a decode of the registered count, never of this cycle's inputs.
    assign empty        = (r_count == '0);
    assign full         = (r_count == DEPTH_C);
    assign almost_empty = (r_count <= AE_C);
    assign almost_full  = (r_count >= AF_C);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // A request is taken only if the registered flags allow it; rejected requests
    // leave pointers, count and memory untouched and only raise the sticky error flag.
    always_comb begin
        w_acc         = '0;
        w_acc.wr_acc  = en_wr & ~full;
        w_acc.rd_acc  = en_rd & ~empty;
        w_acc.ovf_evt = en_wr & full;
        w_acc.unf_evt = en_rd & empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_acc.wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_acc.rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_acc.wr_acc, w_acc.rd_acc})
                2'b10:   r_count <= r_count + PTR_ONE;
                2'b01:   r_count <= r_count - PTR_ONE;
                default: r_count <= r_count;
            endcase
            // A fresh error in the same cycle as clr_err keeps the flag set.
            r_overflow  <= w_acc.ovf_evt | (r_overflow & ~clr_err);
            r_underflow <= w_acc.unf_evt | (r_underflow & ~clr_err);
        end
    end

    syn_fifo_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .REG_RD     ((FWFT == 0) ? 1 : 0)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_acc.wr_acc),
        .i_wr_addr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wr_data (Din),
        .i_rd_en   (w_acc.rd_acc),
        .i_rd_addr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_rd_data (Dout)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout_valid = ~empty;
        end else begin : g_std
            logic r_dout_valid;

            // Pulses for exactly the cycle after an accepted read.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dout_valid <= 1'b0;
                end else begin
                    r_dout_valid <= w_acc.rd_acc;
                end
            end

            assign dout_valid = r_dout_valid;
        end
    endgenerate

endmodule

// File: tb/tb_syn_fifo.sv
// Bench for syn_fifo: a standard and an FWFT instance share one stimulus stream and are
// both compared against a queue-based reference of the FIFO contents and error flags.
module tb_syn_fifo;

    localparam int AW    = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en_wr = 1'b0;
    logic          en_rd = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] Din = '0;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_dv, f_dv, s_empty, f_empty, s_full, f_full;
    logic          s_ae, f_ae, s_af, f_af, s_ovf, f_ovf, s_unf, f_unf;
    logic [AW:0]   s_count, f_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: the stored words in order, sticky flags, and the standard-mode output register.
    logic [DW-1:0] exp_q[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    logic          m_dv = 1'b0;
    logic [DW-1:0] m_dout = '0;

    always #5 clk = ~clk;

    syn_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(0), .AF_LEVEL(3), .AE_LEVEL(1)) u_std (
        .clk(clk), .rst(rst), .en_wr(en_wr), .Din(Din), .en_rd(en_rd),
        .Dout(s_dout), .dout_valid(s_dv), .empty(s_empty), .full(s_full),
        .almost_empty(s_ae), .almost_full(s_af), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf), .clr_err(clr_err)
    );

    syn_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(1)) u_fwft (
        .clk(clk), .rst(rst), .en_wr(en_wr), .Din(Din), .en_rd(en_rd),
        .Dout(f_dout), .dout_valid(f_dv), .empty(f_empty), .full(f_full),
        .almost_empty(f_ae), .almost_full(f_af), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf), .clr_err(clr_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int n;
        n = exp_q.size();
        check_eq("s_count", 32'(s_count), n);
        check_eq("f_count", 32'(f_count), n);
        check_eq("s_empty", 32'(s_empty), 32'(n == 0));
        check_eq("f_empty", 32'(f_empty), 32'(n == 0));
        check_eq("s_full", 32'(s_full), 32'(n == DEPTH));
        check_eq("f_full", 32'(f_full), 32'(n == DEPTH));
        check_eq("s_ae", 32'(s_ae), 32'(n <= 1));
        check_eq("f_ae", 32'(f_ae), 32'(n <= 1));
        check_eq("s_af", 32'(s_af), 32'(n >= 3));
        check_eq("f_af", 32'(f_af), 32'(n >= 3));
        check_eq("s_ovf", 32'(s_ovf), 32'(m_ovf));
        check_eq("f_ovf", 32'(f_ovf), 32'(m_ovf));
        check_eq("s_unf", 32'(s_unf), 32'(m_unf));
        check_eq("f_unf", 32'(f_unf), 32'(m_unf));
        check_eq("s_dv", 32'(s_dv), 32'(m_dv));
        check_eq("s_dout", 32'(s_dout), 32'(m_dout));
        check_eq("f_dv", 32'(f_dv), 32'(n != 0));
        if (n != 0) begin
            check_eq("f_dout", 32'(f_dout), 32'(exp_q[0]));
        end
    endtask

    // One clock: drive at the falling edge, advance the reference, check just after the rising edge.
    task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd,
                        input logic clr, input logic rs);
        bit was_full, was_empty;
        logic [DW-1:0] popped;
        @(negedge clk);
        en_wr = wr; Din = d; en_rd = rd; clr_err = clr; rst = rs;
        was_full  = (exp_q.size() == DEPTH);
        was_empty = (exp_q.size() == 0);
        popped    = '0;
        if (rs) begin
            exp_q.delete();
            m_ovf = 1'b0; m_unf = 1'b0; m_dv = 1'b0; m_dout = '0;
        end else begin
            if (rd && !was_empty) popped = exp_q.pop_front();
            if (wr && !was_full) exp_q.push_back(d);
            m_ovf = (wr && was_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
            m_unf = (rd && was_empty) ? 1'b1 : (clr ? 1'b0 : m_unf);
            m_dv  = rd && !was_empty;
            if (m_dv) m_dout = popped;
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic wr_word(input logic [DW-1:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd_word();
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        do_reset();
        check_eq("rst_count", 32'(s_count), 0);
        check_eq("rst_empty", 32'(s_empty), 1);
        check_eq("rst_dout", 32'(s_dout), 0);

        // Fill to full, then one write too many.
        for (int i = 1; i <= 4; i++) begin
            wr_word(8'hA0 + 8'(i));
            check_eq("fill_count", 32'(s_count), i);
            check_eq("fill_af", 32'(s_af), 32'(i >= 3));
        end
        wr_word(8'hA5);
        check_eq("fill_ovf", 32'(s_ovf), 1);
        check_eq("fill_cnt4", 32'(s_count), 4);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check_eq("clr_ovf", 32'(s_ovf), 0);

        // Drain in order, then one read too many.
        for (int i = 1; i <= 4; i++) begin
            rd_word();
            check_eq("drain_dout", 32'(s_dout), 32'(8'hA0 + 8'(i)));
            check_eq("drain_dv", 32'(s_dv), 1);
        end
        check_eq("drain_empty", 32'(s_empty), 1);
        rd_word();
        check_eq("drain_unf", 32'(s_unf), 1);
        check_eq("drain_dv0", 32'(s_dv), 0);
        check_eq("drain_hold", 32'(s_dout), 32'hA4);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Interleaved pairs walk the pointers around the wrap point.
        for (int i = 0; i < 10; i++) begin
            wr_word(8'(i));
            rd_word();
            check_eq("wrap_dout", 32'(s_dout), i);
            check_eq("wrap_cnt", 32'(s_count), 0);
        end
        check_eq("wrap_ovf", 32'(s_ovf), 0);
        check_eq("wrap_unf", 32'(s_unf), 0);

        // Simultaneous read and write at mid, full and empty.
        wr_word(8'h11); wr_word(8'h22);
        step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        check_eq("sim_mid_cnt", 32'(s_count), 2);
        wr_word(8'h44); wr_word(8'h55);
        step(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
        check_eq("sim_full_cnt", 32'(s_count), 3);
        check_eq("sim_full_ovf", 32'(s_ovf), 1);
        rd_word(); rd_word(); rd_word();
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        check_eq("sim_empty_cnt", 32'(s_count), 1);
        check_eq("sim_empty_unf", 32'(s_unf), 1);

        // FWFT: a word written at one edge is visible straight after it.
        do_reset();
        wr_word(8'h5A);
        check_eq("fwft_dout", 32'(f_dout), 32'h5A);
        check_eq("fwft_dv", 32'(f_dv), 1);
        rd_word();
        check_eq("fwft_empty", 32'(f_empty), 1);

        // Reset in the middle of traffic, and clr_err racing a new overflow.
        for (int i = 0; i < 5; i++) wr_word(8'hC0 + 8'(i));
        rd_word();
        check_eq("mid_cnt3", 32'(s_count), 3);
        check_eq("mid_ovf", 32'(s_ovf), 1);
        do_reset();
        check_eq("mid_rst_cnt", 32'(s_count), 0);
        check_eq("mid_rst_ovf", 32'(s_ovf), 0);
        for (int i = 0; i < 4; i++) wr_word(8'hD0 + 8'(i));
        step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        check_eq("clr_race_ovf", 32'(s_ovf), 1);

        // Random traffic with alternating write-heavy and read-heavy windows.
        for (int i = 0; i < 3000; i++) begin
            int wp;
            logic w, r, c, x;
            wp = ((i / 40) % 2 == 0) ? 75 : 30;
            w  = ($urandom_range(99) < wp);
            r  = ($urandom_range(99) < (100 - wp));
            c  = ($urandom_range(99) < 8);
            x  = ($urandom_range(999) < 4);
            step(w, 8'($urandom_range(255)), r, c, x);
        end

        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
